calib_sweep_ctrl: RTL and testbench

CALIB_SWEEP_CTRL -- requirements
Module: calib_sweep_ctrl

---
 rtl/calib_sweep_ctrl.sv | 161 ++++++++++++++++
 tb/tb_calib_sweep_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/calib_sweep_ctrl.sv
// Calibration sweep controller: sweeps the servo forward along the horizontal
// axis while the max counter tracks the peak, then returns it to the peak by
// counting the max counter back down. The same sequence is then repeated on
// the vertical axis.
//
// state   | code | meaning
// IDLE    | 0    | waiting for START
// SWEEP_H | 1    | horizontal forward sweep, max counter incrementing
// RET_H   | 2    | horizontal return to peak, max counter decrementing
// SWEEP_V | 3    | vertical forward sweep
// RET_V   | 4    | vertical return to peak
// FINISH  | 5    | one-cycle DONE
// FAULT   | 6    | return never reached the peak; held until ABORT or reset
module calib_sweep_ctrl #(
    parameter int SWEEP_STEPS = 180,
    parameter int SETTLE      = 2
) (
    input  logic       CLK,
    input  logic       CNT_RST,
    input  logic       START,
    input  logic       ABORT,
    input  logic       STEP_TICK,
    input  logic       NEW_MAX,
    input  logic       CNT_RU,
    output logic       MC,
    output logic       MAX_RST,
    output logic       SERVO_STEP,
    output logic       SERVO_DIR,
    output logic       AXIS,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [2:0] STATE
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SWEEP_H = 3'd1;
    localparam logic [2:0] S_RET_H   = 3'd2;
    localparam logic [2:0] S_SWEEP_V = 3'd3;
    localparam logic [2:0] S_RET_V   = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    localparam logic [12:0] LAST_POS = 13'(SWEEP_STEPS - 1);
    localparam logic [12:0] END_POS  = 13'(SWEEP_STEPS);

    // Settle window is a down-counter loaded on every state entry; CNT_RU is
    // only trusted once it has reached zero.
    localparam int            SW        = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);

    logic [2:0]    state_q, state_d;
    logic [12:0]   pos_q, pos_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          step_q, step_d;
    logic          max_rst_q, max_rst_d;
    logic          done_q, done_d;
    logic          settled;

    assign settled = (settle_q == '0);

    // Next-state, step position and registered pulse requests.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        settle_d  = settle_q;
        step_d    = 1'b0;
        max_rst_d = 1'b0;
        if (!settled) begin
            settle_d = settle_q - SW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_SWEEP_H;
                end
            end
            S_SWEEP_H, S_SWEEP_V: begin
                max_rst_d = NEW_MAX;
                if (STEP_TICK) begin
                    step_d = 1'b1;
                    pos_d  = pos_q + 13'd1;
                    if (pos_q == LAST_POS) begin
                        state_d = (state_q == S_SWEEP_H) ? S_RET_H : S_RET_V;
                    end
                end
            end
            S_RET_H, S_RET_V: begin
                if (settled) begin
                    if (!CNT_RU) begin
                        state_d = (state_q == S_RET_H) ? S_SWEEP_V : S_FINISH;
                    end else if (pos_q >= END_POS) begin
                        state_d = S_FAULT;
                    end else if (STEP_TICK) begin
                        step_d = 1'b1;
                        pos_d  = pos_q + 13'd1;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
        // ABORT overrides everything and must not leave a pulse behind.
        if (ABORT) begin
            state_d   = S_IDLE;
            step_d    = 1'b0;
            max_rst_d = 1'b0;
        end
        if (state_d != state_q) begin
            pos_d    = '0;
            settle_d = SETTLE_LD;
            if (state_d == S_SWEEP_H || state_d == S_SWEEP_V) begin
                max_rst_d = 1'b1;
            end
        end
        done_d = (state_d == S_FINISH);
    end

    // State and pulse registers with asynchronous reset.
    always_ff @(posedge CLK or posedge CNT_RST) begin
        if (CNT_RST) begin
            state_q   <= S_IDLE;
            pos_q     <= '0;
            settle_q  <= '0;
            step_q    <= 1'b0;
            max_rst_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            settle_q  <= settle_d;
            step_q    <= step_d;
            max_rst_q <= max_rst_d;
            done_q    <= done_d;
        end
    end

    // Level outputs decoded from the registered state.
    always_comb begin
        MC        = 1'b0;
        SERVO_DIR = 1'b0;
        AXIS      = 1'b0;
        BUSY      = 1'b0;
        ERR       = 1'b0;
        case (state_q)
            S_SWEEP_H: begin SERVO_DIR = 1'b1; BUSY = 1'b1; end
            S_SWEEP_V: begin SERVO_DIR = 1'b1; AXIS = 1'b1; BUSY = 1'b1; end
            S_RET_H:   begin MC = 1'b1; BUSY = 1'b1; end
            S_RET_V:   begin MC = 1'b1; AXIS = 1'b1; BUSY = 1'b1; end
            S_FAULT:   ERR = 1'b1;
            default:   ;
        endcase
    end

    assign MAX_RST    = max_rst_q;
    assign SERVO_STEP = step_q;
    assign DONE       = done_q;
    assign STATE      = state_q;

endmodule

// File: tb/tb_calib_sweep_ctrl.sv
// Bench for calib_sweep_ctrl: directed scenarios plus a randomized stretch,
// every cycle compared against a behavioural model of the sweep sequence.
module tb_calib_sweep_ctrl;

    localparam int STEPS  = 8;
    localparam int SETTLE = 2;

    logic       CLK = 1'b0;
    logic       CNT_RST = 1'b1;
    logic       START = 1'b0, ABORT = 1'b0, STEP_TICK = 1'b0, NEW_MAX = 1'b0, CNT_RU = 1'b0;
    logic       MC, MAX_RST, SERVO_STEP, SERVO_DIR, AXIS, BUSY, DONE, ERR;
    logic [2:0] STATE;

    calib_sweep_ctrl #(.SWEEP_STEPS(STEPS), .SETTLE(SETTLE)) dut (
        .CLK(CLK), .CNT_RST(CNT_RST), .START(START), .ABORT(ABORT),
        .STEP_TICK(STEP_TICK), .NEW_MAX(NEW_MAX), .CNT_RU(CNT_RU),
        .MC(MC), .MAX_RST(MAX_RST), .SERVO_STEP(SERVO_STEP), .SERVO_DIR(SERVO_DIR),
        .AXIS(AXIS), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_step, cnt_mr, cnt_done;

    // Model: phase code, steps taken in phase, cycles spent in phase, pulses.
    int m_state, m_pos, m_age;
    bit m_step, m_mr, m_done;

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_age = 0;
        m_step = 0; m_mr = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit st, input bit ab, input bit tk, input bit nm, input bit ru);
        int ns;
        bit step, mr;
        ns = m_state; step = 0; mr = 0;
        if (ab) ns = 0;
        else begin
            case (m_state)
                0: if (st) ns = 1;
                1, 3: begin
                    mr = nm;
                    if (tk) begin
                        step = 1;
                        if (m_pos == STEPS - 1) ns = m_state + 1;
                    end
                end
                2, 4: if (m_age >= SETTLE) begin
                    if (!ru) ns = (m_state == 2) ? 3 : 5;
                    else if (m_pos >= STEPS) ns = 6;
                    else if (tk) step = 1;
                end
                5: ns = 0;
                6: ns = 6;
                default: ns = 0;
            endcase
        end
        if (ns != m_state) begin
            m_pos = 0; m_age = 0;
            if (ns == 1 || ns == 3) mr = 1;
        end else begin
            if (step) m_pos++;
            if (m_age < 1000) m_age++;
        end
        m_step = step; m_mr = mr; m_done = (ns == 5); m_state = ns;
    endtask

    function automatic logic [10:0] exp_vec();
        logic [10:0] v;
        v[10:8] = 3'(m_state);
        v[7] = (m_state == 2 || m_state == 4);
        v[6] = m_mr;
        v[5] = m_step;
        v[4] = (m_state == 1 || m_state == 3);
        v[3] = (m_state == 3 || m_state == 4);
        v[2] = (m_state >= 1 && m_state <= 4);
        v[1] = m_done;
        v[0] = (m_state == 6);
        return v;
    endfunction

    function automatic logic [10:0] obs_vec();
        return {STATE, MC, MAX_RST, SERVO_STEP, SERVO_DIR, AXIS, BUSY, DONE, ERR};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, step the model at the edge, compare just after.
    task automatic cyc(input bit st, input bit ab, input bit tk, input bit nm, input bit ru, input string tag);
        START = st; ABORT = ab; STEP_TICK = tk; NEW_MAX = nm; CNT_RU = ru;
        @(posedge CLK);
        model_edge(st, ab, tk, nm, ru);
        #1;
        check(tag, 32'(obs_vec()), 32'(exp_vec()));
        cnt_step += int'(SERVO_STEP);
        cnt_mr   += int'(MAX_RST);
        cnt_done += int'(DONE);
    endtask

    task automatic clear_counts();
        cnt_step = 0; cnt_mr = 0; cnt_done = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_counts();
        model_reset();

        // Reset values, then the first START after release.
        #12;
        check("reset_vals", 32'(obs_vec()), 32'(exp_vec()));
        check("reset_zero", 32'(obs_vec()), 32'd0);
        CNT_RST = 1'b0;

        // Full H+V run with NEW_MAX at tick 3 and random tick spacing.
        cyc(1, 0, 0, 0, 0, "first_start");
        check("first_start_state", 32'(STATE), 32'd1);
        for (int t = 1; t <= STEPS; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) cyc(0, 0, 0, 0, 1, "h_gap");
            cyc(0, 0, 1, (t == 3), 1, "h_tick");
        end
        check("ret_h_axis", 32'(AXIS), 32'd0);
        for (int g = 0; g < SETTLE; g++) cyc(0, 0, 1, 0, 0, "h_settle");
        for (int r = 0; r < 5; r++) begin
            if ($urandom_range(0, 1) == 1) cyc(0, 0, 0, 0, 1, "h_ret_gap");
            cyc(0, 0, 1, 0, 1, "h_ret");
        end
        cyc(0, 0, 1, 0, 0, "h_ret_end");
        check("h_steps", 32'(cnt_step), 32'(STEPS + 5));
        check("h_maxrst", 32'(cnt_mr), 32'd3);
        check("axis_v", 32'(AXIS), 32'd1);
        for (int t = 1; t <= STEPS; t++) begin
            if ($urandom_range(0, 2) == 0) cyc(0, 0, 0, 0, 1, "v_gap");
            cyc(0, 0, 1, 0, 1, "v_tick");
        end
        for (int g = 0; g < SETTLE; g++) cyc(0, 0, 0, 0, 1, "v_settle");
        for (int r = 0; r < 3; r++) cyc(0, 0, 1, 0, 1, "v_ret");
        cyc(0, 0, 0, 0, 0, "v_ret_end");
        check("finish_state", 32'(STATE), 32'd5);
        check("finish_done", 32'(DONE), 32'd1);
        cyc(1, 0, 0, 0, 0, "finish_start_ignored");
        check("idle_after_finish", 32'(STATE), 32'd0);
        check("busy_after_finish", 32'(BUSY), 32'd0);
        cyc(0, 0, 0, 0, 0, "idle_quiet");
        check("done_count", 32'(cnt_done), 32'd1);
        check("total_steps", 32'(cnt_step), 32'(2 * STEPS + 8));

        // NEW_MAX on the last tick, then CNT_RU stuck high -> FAULT, ABORT out.
        clear_counts();
        cyc(1, 0, 0, 0, 0, "f_start");
        for (int t = 1; t <= STEPS; t++) cyc(0, 0, 1, (t == STEPS), 1, "f_tick");
        check("lasttick_state", 32'(STATE), 32'd2);
        check("lasttick_maxrst", 32'(MAX_RST), 32'd1);
        clear_counts();
        n = 0;
        while (STATE !== 3'd6 && n < 40) begin
            cyc(0, 0, 1, 0, 1, "f_stuck");
            n++;
        end
        check("fault_reached", 32'(n < 40), 32'd1);
        check("fault_ret_steps", 32'(cnt_step), 32'(STEPS));
        check("fault_err", 32'(ERR), 32'd1);
        cyc(1, 0, 1, 1, 1, "fault_hold");
        check("fault_held", 32'(STATE), 32'd6);
        cyc(1, 1, 0, 0, 0, "fault_abort");
        check("abort_state", 32'(STATE), 32'd0);
        check("abort_err", 32'(ERR), 32'd0);

        // ABORT during SWEEP_V step 4.
        clear_counts();
        cyc(1, 0, 0, 0, 0, "a_start");
        for (int t = 1; t <= STEPS; t++) cyc(0, 0, 1, 0, 1, "a_htick");
        for (int g = 0; g < SETTLE; g++) cyc(0, 0, 0, 0, 1, "a_settle");
        cyc(0, 0, 0, 0, 0, "a_to_v");
        for (int t = 1; t <= 4; t++) cyc(0, 0, 1, 0, 1, "a_vtick");
        cyc(1, 1, 1, 1, 1, "a_abort");
        check("abort_v_state", 32'(STATE), 32'd0);
        clear_counts();
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1, 1, "a_after");
        check("abort_no_steps", 32'(cnt_step), 32'd0);
        check("abort_no_done", 32'(cnt_done), 32'd0);

        // Asynchronous reset mid-RET_H with a step pulse on the wire.
        cyc(1, 0, 0, 0, 0, "r_start");
        for (int t = 1; t <= STEPS; t++) cyc(0, 0, 1, 0, 1, "r_tick");
        for (int g = 0; g < SETTLE; g++) cyc(0, 0, 0, 0, 1, "r_settle");
        cyc(0, 0, 1, 0, 1, "r_ret1");
        cyc(0, 0, 1, 0, 1, "r_ret2");
        #3;
        CNT_RST = 1'b1;
        #1;
        model_reset();
        check("async_rst_outputs", 32'(obs_vec()), 32'd0);
        @(posedge CLK);
        #1;
        check("rst_held_outputs", 32'(obs_vec()), 32'd0);
        CNT_RST = 1'b0;
        cyc(1, 0, 1, 0, 1, "r_restart");
        check("restart_state", 32'(STATE), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                $urandom_range(0, 7) != 0, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
